// File: rtl/eu_iqueue.sv
// eu_iqueue: per-EU circular instruction FIFO presenting a stable show-ahead head to the EU cache
package eu_iqueue_pkg;
    typedef logic [15:0] type_iqueue_entry;
endpackage

module eu_iqueue
    import eu_iqueue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             enq_valid_i,
    output logic             enq_ready_o,
    input  type_iqueue_entry enq_instr_i,
    output logic             curr_valid_o,
    output type_iqueue_entry curr_instr_o,
    input  logic             curr_ack_i,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int PTR_W = $clog2(DEPTH);

    type_iqueue_entry mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic push, pop;

    assign full_o       = count == CNT_W'(DEPTH);
    assign empty_o      = count == '0;
    assign enq_ready_o  = !full_o;
    assign curr_valid_o = !empty_o;
    assign count_o      = count;
    assign push         = enq_valid_i && enq_ready_o;
    assign pop          = curr_ack_i && curr_valid_o;
    // Head is only ever rewritten after it is popped, since wr_ptr != rd_ptr whenever count is 1..DEPTH-1
    assign curr_instr_o = curr_valid_o ? mem[rd_ptr] : '0;

    // Entry storage; flushed or reset cycles write nothing
    always_ff @(posedge clk) begin
        if (push && !flush_i && !reset) mem[wr_ptr] <= enq_instr_i;
    end

    // Pointers and occupancy; reset dominates flush, flush dominates push/pop
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Occupancy must never exceed DEPTH nor wrap below zero
    always_ff @(posedge clk) begin
        if (!reset) assert (count <= CNT_W'(DEPTH));
    end
endmodule
